// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the addu/subu/ori/lw/sw/beq/lui subset.
// Outputs decode from the current state and the latched opcode; stalls on imem/dmem ready.
module mc_ctrl #(
  parameter int ILLEGAL_HALT = 0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_rd,
  output logic             ir_write,
  output logic             pc_write,
  output logic             npc_sel,
  output logic             Regdst,
  output logic             Alusrc,
  output logic             Memtoreg,
  output logic             Regwrite,
  output logic             Memwrite,
  output logic             dmem_rd,
  output logic             Extop,
  output logic [1:0]       Aluop,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  state_t     st;
  logic [5:0] op_q;
  logic [5:0] funct_q;

  logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_illegal;
  logic retire;

  always_comb begin
    is_addu    = (op_q == 6'b000000) && (funct_q == 6'b100001);
    is_subu    = (op_q == 6'b000000) && (funct_q == 6'b100011);
    is_ori     = (op_q == 6'b001101);
    is_lw      = (op_q == 6'b100011);
    is_sw      = (op_q == 6'b101011);
    is_beq     = (op_q == 6'b000100);
    is_lui     = (op_q == 6'b001111);
    is_illegal = !(is_addu || is_subu || is_ori || is_lw || is_sw || is_beq || is_lui);
  end

  // Every path back to IF (except HALT entry) retires exactly one instruction.
  always_comb begin
    retire = 1'b0;
    case (st)
      S_ID:    retire = is_illegal && (ILLEGAL_HALT == 0);
      S_EX:    retire = is_beq;
      S_MEM:   retire = is_sw && dmem_ready;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IF;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
      instret <= '0;
    end else begin
      case (st)
        S_IF: begin
          if (imem_ready) begin
            op_q    <= op;
            funct_q <= funct;
            st      <= S_ID;
          end
        end
        S_ID: begin
          if (!is_illegal)             st <= S_EX;
          else if (ILLEGAL_HALT != 0)  st <= S_HALT;
          else                         st <= S_IF;
        end
        S_EX: begin
          if (is_beq)              st <= S_IF;
          else if (is_lw || is_sw) st <= S_MEM;
          else                     st <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) st <= is_lw ? S_WB : S_IF;
        end
        S_WB:    st <= S_IF;
        S_HALT:  st <= S_HALT;
        default: st <= S_IF;
      endcase
      if (retire) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Datapath control fields are only presented while the instruction is executing,
  // so IF/ID/HALT always show a quiet bus regardless of the previous instruction.
  always_comb begin
    imem_rd  = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    npc_sel  = 1'b0;
    Regdst   = 1'b0;
    Alusrc   = 1'b0;
    Memtoreg = 1'b0;
    Regwrite = 1'b0;
    Memwrite = 1'b0;
    dmem_rd  = 1'b0;
    Extop    = 1'b0;
    Aluop    = 2'b00;
    if (st == S_EX || st == S_MEM || st == S_WB) begin
      Regdst   = is_addu || is_subu;
      Alusrc   = is_ori || is_lui || is_lw || is_sw;
      Memtoreg = is_lw;
      Extop    = is_lw || is_sw || is_beq;
      if (is_subu || is_beq) Aluop = 2'b01;
      else if (is_ori)       Aluop = 2'b10;
      else if (is_lui)       Aluop = 2'b11;
    end
    case (st)
      S_IF: begin
        imem_rd  = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EX: begin
        if (is_beq) begin
          pc_write = zero;
          npc_sel  = 1'b1;
        end
      end
      S_MEM: begin
        dmem_rd  = is_lw;
        Memwrite = is_sw;
      end
      S_WB:    Regwrite = 1'b1;
      default: ;
    endcase
  end

  assign state  = st;
  assign halted = (st == S_HALT);

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations queued per instruction, then replayed.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, imem_ready, dmem_ready;

  // Main instance: defaults (illegal retires as NOP, 32-bit counter).
  logic        a_imem_rd, a_ir_write, a_pc_write, a_npc_sel, a_Regdst, a_Alusrc, a_Memtoreg;
  logic        a_Regwrite, a_Memwrite, a_dmem_rd, a_Extop, a_halted;
  logic [1:0]  a_Aluop;
  logic [2:0]  a_state;
  logic [31:0] a_instret;

  // Second instance: halting on illegal, 2-bit counter to exercise wrap.
  logic        h_imem_rd, h_ir_write, h_pc_write, h_npc_sel, h_Regdst, h_Alusrc, h_Memtoreg;
  logic        h_Regwrite, h_Memwrite, h_dmem_rd, h_Extop, h_halted;
  logic [1:0]  h_Aluop;
  logic [2:0]  h_state;
  logic [1:0]  h_instret;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_rd(a_imem_rd), .ir_write(a_ir_write), .pc_write(a_pc_write), .npc_sel(a_npc_sel),
    .Regdst(a_Regdst), .Alusrc(a_Alusrc), .Memtoreg(a_Memtoreg), .Regwrite(a_Regwrite),
    .Memwrite(a_Memwrite), .dmem_rd(a_dmem_rd), .Extop(a_Extop), .Aluop(a_Aluop),
    .state(a_state), .halted(a_halted), .instret(a_instret)
  );

  mc_ctrl #(.ILLEGAL_HALT(1), .CNT_W(2)) dut_h (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_rd(h_imem_rd), .ir_write(h_ir_write), .pc_write(h_pc_write), .npc_sel(h_npc_sel),
    .Regdst(h_Regdst), .Alusrc(h_Alusrc), .Memtoreg(h_Memtoreg), .Regwrite(h_Regwrite),
    .Memwrite(h_Memwrite), .dmem_rd(h_dmem_rd), .Extop(h_Extop), .Aluop(h_Aluop),
    .state(h_state), .halted(h_halted), .instret(h_instret)
  );

  typedef struct packed {
    logic [2:0]  state;
    logic        halted, imem_rd, ir_write, pc_write, npc_sel;
    logic        Regdst, Alusrc, Memtoreg, Regwrite, Memwrite, dmem_rd, Extop;
    logic [1:0]  Aluop;
    logic [31:0] instret;
  } exp_t;

  typedef struct {
    logic       rst, iready, dready, z;
    logic [5:0] op, funct;
    exp_t       exp;
    int         hmode;   // 1: halting instance tracks main, 2: halting instance parked in HALT
    logic [1:0] hcnt;
  } step_t;

  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_ILL} kind_t;

  step_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [31:0] cnt   = 0;
  int         hmode  = 1;
  logic [1:0] hcnt   = 2'd0;
  exp_t       obs;

  always_comb begin
    obs = '0;
    obs.state    = a_state;    obs.halted   = a_halted;   obs.imem_rd  = a_imem_rd;
    obs.ir_write = a_ir_write; obs.pc_write = a_pc_write; obs.npc_sel  = a_npc_sel;
    obs.Regdst   = a_Regdst;   obs.Alusrc   = a_Alusrc;   obs.Memtoreg = a_Memtoreg;
    obs.Regwrite = a_Regwrite; obs.Memwrite = a_Memwrite; obs.dmem_rd  = a_dmem_rd;
    obs.Extop    = a_Extop;    obs.Aluop    = a_Aluop;    obs.instret  = a_instret;
  end

  function automatic logic [5:0] rnd6();
    logic [5:0] r;
    r = 6'($urandom_range(63, 0));
    return r;
  endfunction

  function automatic exp_t base(input logic [2:0] st, input logic [31:0] n);
    exp_t e;
    e = '0;
    e.state   = st;
    e.halted  = (st == 3'd7);
    e.instret = n;
    return e;
  endfunction

  function automatic exp_t fields(input exp_t ein, input kind_t k);
    exp_t e;
    e = ein;
    case (k)
      K_ADDU: begin e.Regdst = 1'b1; e.Aluop = 2'b00; end
      K_SUBU: begin e.Regdst = 1'b1; e.Aluop = 2'b01; end
      K_ORI:  begin e.Alusrc = 1'b1; e.Extop = 1'b0; e.Aluop = 2'b10; end
      K_LUI:  begin e.Alusrc = 1'b1; e.Aluop = 2'b11; end
      K_LW:   begin e.Alusrc = 1'b1; e.Extop = 1'b1; e.Memtoreg = 1'b1; end
      K_SW:   begin e.Alusrc = 1'b1; e.Extop = 1'b1; end
      K_BEQ:  begin e.Extop = 1'b1; e.Aluop = 2'b01; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic add_step(input logic rst, input logic ir, input logic dr, input logic z,
                          input logic [5:0] o, input logic [5:0] f, input exp_t e);
    step_t s;
    s.rst = rst; s.iready = ir; s.dready = dr; s.z = z;
    s.op = o; s.funct = f; s.exp = e; s.hmode = hmode; s.hcnt = hcnt;
    sb.push_back(s);
  endtask

  // Queue the cycle-by-cycle trace of one instruction; non-sampled cycles carry noise on op/funct.
  task automatic push_instr(input kind_t k, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int istall, input int dstall, input bit rst_in_mem);
    exp_t e;
    for (int i = 0; i < istall; i++) begin
      e = base(3'd0, cnt); e.imem_rd = 1'b1;
      add_step(1'b0, 1'b0, 1'b1, 1'b0, rnd6(), rnd6(), e);
    end
    e = base(3'd0, cnt); e.imem_rd = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    add_step(1'b0, 1'b1, 1'b1, 1'b0, o, f, e);
    e = base(3'd1, cnt);
    add_step(1'b0, 1'b1, 1'b1, ~z, rnd6(), rnd6(), e);
    if (k == K_ILL) begin
      cnt = cnt + 1;
      return;
    end
    e = fields(base(3'd2, cnt), k);
    if (k == K_BEQ) begin
      e.pc_write = z; e.npc_sel = 1'b1;
      add_step(1'b0, 1'b1, 1'b1, z, rnd6(), rnd6(), e);
      cnt = cnt + 1;
      return;
    end
    add_step(1'b0, 1'b1, 1'b1, ~z, rnd6(), rnd6(), e);
    if (k == K_LW || k == K_SW) begin
      for (int d = 0; d < dstall; d++) begin
        e = fields(base(3'd3, cnt), k);
        e.dmem_rd = (k == K_LW); e.Memwrite = (k == K_SW);
        add_step(rst_in_mem && (d == dstall - 1), 1'b1, 1'b0, 1'b0, rnd6(), rnd6(), e);
      end
      if (rst_in_mem) begin
        cnt = 0;
        return;
      end
      e = fields(base(3'd3, cnt), k);
      e.dmem_rd = (k == K_LW); e.Memwrite = (k == K_SW);
      add_step(1'b0, 1'b1, 1'b1, 1'b0, rnd6(), rnd6(), e);
      if (k == K_SW) begin
        cnt = cnt + 1;
        return;
      end
    end
    e = fields(base(3'd4, cnt), k); e.Regwrite = 1'b1;
    add_step(1'b0, 1'b1, 1'b1, 1'b0, rnd6(), rnd6(), e);
    cnt = cnt + 1;
  endtask

  initial begin
    step_t s;
    int    n;
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    assert ({a_state, a_imem_rd, a_ir_write, a_pc_write, a_Regwrite, a_Memwrite, a_dmem_rd,
             a_Aluop, a_Extop, a_Regdst, a_Alusrc, a_Memtoreg, a_instret}
            === {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0})
    else begin
      errors++;
      $error("FAIL reset_state observed state=%0d imem_rd=%0b instret=%0d expected state=0 imem_rd=1 instret=0",
             a_state, a_imem_rd, a_instret);
    end

    push_instr(K_ADDU, 6'b000000, 6'b100001, 1'b0, 0, 0, 1'b0);
    push_instr(K_LW,   6'b100011, rnd6(),    1'b0, 0, 3, 1'b0);
    push_instr(K_BEQ,  6'b000100, rnd6(),    1'b1, 0, 0, 1'b0);
    push_instr(K_BEQ,  6'b000100, rnd6(),    1'b0, 0, 0, 1'b0);
    push_instr(K_SW,   6'b101011, rnd6(),    1'b0, 0, 0, 1'b0);
    push_instr(K_ORI,  6'b001101, rnd6(),    1'b0, 0, 0, 1'b0);
    push_instr(K_LUI,  6'b001111, rnd6(),    1'b0, 0, 0, 1'b0);
    push_instr(K_SUBU, 6'b000000, 6'b100011, 1'b0, 2, 0, 1'b0);
    hcnt = cnt[1:0];
    push_instr(K_ILL,  6'b111111, rnd6(),    1'b0, 0, 0, 1'b0);
    hmode = 2;
    push_instr(K_ADDU, 6'b000000, 6'b100001, 1'b0, 0, 0, 1'b0);
    push_instr(K_SW,   6'b101011, rnd6(),    1'b0, 0, 2, 1'b1);
    hmode = 1;
    push_instr(K_ADDU, 6'b000000, 6'b100001, 1'b0, 1, 0, 1'b0);
    push_instr(K_LW,   6'b100011, rnd6(),    1'b0, 0, 0, 1'b0);
    hcnt = cnt[1:0];
    push_instr(K_ILL,  6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0);
    hmode = 2;
    push_instr(K_ORI,  6'b001101, rnd6(),    1'b0, 0, 0, 1'b0);

    n = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; imem_ready = s.iready; dmem_ready = s.dready; zero = s.z;
      op = s.op; funct = s.funct;
      #1;
      checks++;
      assert (obs === s.exp)
      else begin
        errors++;
        $error("FAIL step%0d ctrl observed %h expected %h", n, obs, s.exp);
      end
      if (s.hmode == 1) begin
        checks++;
        assert ({h_state, h_instret} === {s.exp.state, s.exp.instret[1:0]})
        else begin
          errors++;
          $error("FAIL step%0d halt_inst_track observed state=%0d instret=%0d expected state=%0d instret=%0d",
                 n, h_state, h_instret, s.exp.state, s.exp.instret[1:0]);
        end
      end else begin
        checks++;
        assert ({h_state, h_halted, h_imem_rd, h_ir_write, h_pc_write, h_Regwrite, h_Memwrite, h_dmem_rd, h_instret}
                === {3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s.hcnt})
        else begin
          errors++;
          $error("FAIL step%0d halt_inst_parked observed state=%0d halted=%0b imem_rd=%0b instret=%0d expected state=7 halted=1 imem_rd=0 instret=%0d",
                 n, h_state, h_halted, h_imem_rd, h_instret, s.hcnt);
        end
      end
      n++;
      @(posedge clk);
      #2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
